// File: rtl/pattern_mem.sv
// pattern_mem: DEPTH-word pattern memory with a 1-cycle registered read and a reset-restored preset pattern.
// Optional scan mode (SCAN state, scan pointer, step counter, scan_wrap) is built only with `define PATTERN_MEM_SCAN_EN.
module pattern_mem #(
  parameter int NBITS_DATA = 4,
  parameter int NBITS_ADDR = 2,
  parameter int SCAN_DIV   = 4
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic                  we,
  input  logic [NBITS_ADDR-1:0] addr,
  input  logic [NBITS_DATA-1:0] wdata,
  input  logic                  scan,
  output logic [NBITS_DATA-1:0] rdata,
  output logic [NBITS_ADDR-1:0] raddr,
  output logic                  valid,
  output logic                  scan_wrap
);

  localparam int DEPTH  = 2 ** NBITS_ADDR;
  localparam int STEP_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  function automatic logic [NBITS_DATA-1:0] init_word(input int i);
    return NBITS_DATA'((i + 1) * 3);
  endfunction

  logic [NBITS_DATA-1:0] mem_q [DEPTH];
  logic [NBITS_DATA-1:0] rdata_q;
  logic [NBITS_ADDR-1:0] raddr_q;
  logic                  valid_q;
  logic [NBITS_ADDR-1:0] rd_addr;
  logic                  wr_en;

`ifdef PATTERN_MEM_SCAN_EN
  typedef enum logic {DIRECT, SCAN} state_e;

  state_e              state_q, state_d;
  logic [NBITS_ADDR-1:0] ptr_q, ptr_d;
  logic [STEP_W-1:0]     step_q, step_d;
  logic                  wrap_q, wrap_d;

  // NOTE: every next-state signal gets its hold value first, so no path through this block can infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    step_d  = step_q;
    wrap_d  = 1'b0;
    case (state_q)
      DIRECT: begin
        if (scan) begin
          state_d = SCAN;
          ptr_d   = '0;
          step_d  = '0;
        end
      end
      SCAN: begin
        if (!scan) begin
          state_d = DIRECT;
        end else if (step_q == STEP_W'(SCAN_DIV - 1)) begin
          step_d = '0;
          ptr_d  = ptr_q + NBITS_ADDR'(1);
          wrap_d = (ptr_q == NBITS_ADDR'(DEPTH - 1));
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      default: state_d = DIRECT;
    endcase
  end

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q <= DIRECT;
      ptr_q   <= '0;
      step_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  // The pointer is kept across a return to DIRECT but only drives the read while scanning.
  assign rd_addr   = (state_q == SCAN) ? ptr_q : addr;
  assign wr_en     = we && (state_q == DIRECT);
  assign scan_wrap = wrap_q;
`else
  logic unused_scan;

  assign unused_scan = scan;
  assign rd_addr     = addr;
  assign wr_en       = we;
  assign scan_wrap   = 1'b0;
`endif

  // NOTE: the storage array is reset on purpose -- reset restores the preset pattern, so it cannot map to a plain RAM macro.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= init_word(i);
      end
      rdata_q <= '0;
      raddr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates make a same-edge read of the written word return the old value (read-first).
      if (wr_en) begin
        mem_q[addr] <= wdata;
      end
      rdata_q <= mem_q[rd_addr];
      raddr_q <= rd_addr;
      valid_q <= 1'b1;
    end
  end

  assign rdata = rdata_q;
  assign raddr = raddr_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_pattern_mem.sv
// tb_pattern_mem: scoreboard bench for pattern_mem; default instance plus an 8-bit/16-word instance.
// Scan-mode scenarios are exercised when PATTERN_MEM_SCAN_EN is defined, the scan-ignored scenario otherwise.
module tb_pattern_mem;

`ifdef PATTERN_MEM_SCAN_EN
  localparam bit SCAN_EN = 1'b1;
`else
  localparam bit SCAN_EN = 1'b0;
`endif
  localparam int SCAN_DIV = 4;

  typedef struct packed {
    logic       v;
    logic [3:0] a;
    logic [7:0] d;
    logic       w;
  } exp_t;

  logic       clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  // Default instance (4-bit data, 4 words)
  logic       reset, we, scan;
  logic [1:0] addr;
  logic [3:0] wdata;
  logic [3:0] rdata;
  logic [1:0] raddr;
  logic       valid, scan_wrap;

  // Wide instance (8-bit data, 16 words)
  logic       reset8, we8, scan8;
  logic [3:0] addr8;
  logic [7:0] wdata8;
  logic [7:0] rdata8;
  logic [3:0] raddr8;
  logic       valid8, scan_wrap8;

  pattern_mem #(.NBITS_DATA(4), .NBITS_ADDR(2), .SCAN_DIV(SCAN_DIV)) u_dut (
    .clk_2(clk_2), .reset(reset), .we(we), .addr(addr), .wdata(wdata), .scan(scan),
    .rdata(rdata), .raddr(raddr), .valid(valid), .scan_wrap(scan_wrap)
  );

  pattern_mem #(.NBITS_DATA(8), .NBITS_ADDR(4), .SCAN_DIV(SCAN_DIV)) u_dut8 (
    .clk_2(clk_2), .reset(reset8), .we(we8), .addr(addr8), .wdata(wdata8), .scan(scan8),
    .rdata(rdata8), .raddr(raddr8), .valid(valid8), .scan_wrap(scan_wrap8)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_wraps  = 0;
  exp_t sb  [$];
  exp_t sb8 [$];

  int   m_mem [4];
  int   m8    [16];
  bit   m_scan;
  int   m_ptr, m_step;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock of the default instance: drive, predict, push, clock, pop and compare.
  task automatic step(input bit r, input bit s, input bit w, input int a, input int d);
    exp_t e;
    int   ra;
    reset = r; scan = s; we = w; addr = a[1:0]; wdata = d[3:0];
    e = '0;
    if (r) begin
      m_mem  = '{3, 6, 9, 12};
      m_scan = 1'b0;
      m_ptr  = 0;
      m_step = 0;
    end else begin
      ra  = m_scan ? m_ptr : a;
      e.v = 1'b1;
      e.a = 4'(ra);
      e.d = 8'(m_mem[ra]);
      if (!m_scan && w) m_mem[a] = d;
      if (!m_scan) begin
        if (SCAN_EN && s) begin
          m_scan = 1'b1;
          m_ptr  = 0;
          m_step = 0;
        end
      end else if (!s) begin
        m_scan = 1'b0;
      end else if (m_step == SCAN_DIV - 1) begin
        m_step = 0;
        e.w    = (m_ptr == 3);
        m_ptr  = (m_ptr + 1) % 4;
      end else begin
        m_step++;
      end
    end
    sb.push_back(e);
    @(posedge clk_2);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("valid", {31'd0, valid}, {31'd0, e.v});
      check("raddr", {30'd0, raddr}, {28'd0, e.a});
      check("rdata", {28'd0, rdata}, {24'd0, e.d});
      check("scan_wrap", {31'd0, scan_wrap}, {31'd0, e.w});
      if (scan_wrap) n_wraps++;
    end
  endtask

  task automatic step8(input bit r, input bit w, input int a, input int d);
    exp_t e;
    reset8 = r; scan8 = 1'b0; we8 = w; addr8 = a[3:0]; wdata8 = d[7:0];
    e = '0;
    if (r) begin
      for (int i = 0; i < 16; i++) m8[i] = ((i + 1) * 3) % 256;
    end else begin
      e.v = 1'b1;
      e.a = 4'(a);
      e.d = 8'(m8[a]);
      if (w) m8[a] = d;
    end
    sb8.push_back(e);
    @(posedge clk_2);
    #1;
    if (sb8.size() == 0) begin
      check("sb8_empty", 32'd1, 32'd0);
    end else begin
      e = sb8.pop_front();
      check("valid8", {31'd0, valid8}, {31'd0, e.v});
      check("raddr8", {28'd0, raddr8}, {28'd0, e.a});
      check("rdata8", {24'd0, rdata8}, {24'd0, e.d});
      check("scan_wrap8", {31'd0, scan_wrap8}, 32'd0);
    end
  endtask

  initial begin
    reset = 1'b0; we = 1'b0; scan = 1'b0; addr = '0; wdata = '0;
    reset8 = 1'b1; we8 = 1'b0; scan8 = 1'b0; addr8 = '0; wdata8 = '0;
    m_mem = '{3, 6, 9, 12};

    // Reset, then the preset pattern read back with 1-cycle latency
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, i, 0);

    // Same-cycle write/read of one address is read-first
    step(0, 0, 1, 2, 5);
    step(0, 0, 0, 2, 0);
    check("read_first_new", {28'd0, rdata}, 32'd5);

    if (SCAN_EN) begin
      // Enter scan, then hold scan with writes attempted every cycle
      n_wraps = 0;
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < 20; i++) step(0, 1, 1, i % 4, 15);
      check("wrap_count", n_wraps, 32'd1);
      for (int i = 0; i < 4; i++) step(0, 0, 0, i, 0);
    end else begin
      // scan is ignored: the write lands and no wrap ever appears
      n_wraps = 0;
      step(0, 1, 1, 3, 0);
      step(0, 1, 0, 3, 0);
      check("noscan_rd3", {28'd0, rdata}, 32'd0);
      for (int i = 0; i < 8; i++) step(0, 1, 0, i % 4, 0);
      check("noscan_wraps", n_wraps, 32'd0);
    end

    // Write addr 1, scan a few cycles, reset mid-scan; pattern comes back
    step(0, 0, 1, 1, 10);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 1, 7);
    step(1, 1, 1, 1, 7);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_rdata", {28'd0, rdata}, 32'd0);
    step(0, 0, 0, 1, 0);
    check("rst_rd1", {28'd0, rdata}, 32'd6);
    step(0, 0, 0, 0, 0);

    // Wide instance: preset at the top address, then full write/read-back
    step8(1, 0, 0, 0);
    step8(0, 0, 15, 0);
    check("wide_rd15", {24'd0, rdata8}, 32'h30);
    for (int i = 0; i < 16; i++) step8(0, 1, i, int'($urandom_range(0, 255)));
    for (int i = 0; i < 16; i++) step8(0, 0, i, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
